// File: rtl/dac_stream_pkg.sv
// Shared types for the DAC sample streamer: FSM states and mode encodings.
// No logic; imported by the streamer top.
package dac_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic MODE_BCAST = 1'b0;
    localparam logic MODE_ILV   = 1'b1;

endpackage

// File: rtl/dac_stream_fifo.sv
// Generic synchronous FIFO with extra-bit pointers and an occupancy count.
// Latency: written word is poppable the cycle after the push; no write-through.
// Backpressure: pushes while full and pops while empty are dropped.
module dac_stream_fifo #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_dat,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_dat,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dac_sample_streamer.sv
// Buffers core samples and releases them to DAC lanes at a programmable rate.
// Latency: lanes register one cycle after the tick that pops the word.
// Backpressure: in_ready drops while the FIFO is full; excess pushes set overflow.
module dac_sample_streamer
    import dac_stream_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         mode,
    input  logic [DIV_W-1:0]             div,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    input  logic                         clr_flags,
    output logic [CHANNELS*DATA_W-1:0]   dac_out,
    output logic [CHANNELS-1:0]          dac_en,
    output logic                         sample_strobe,
    output logic                         underrun,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  cnt;
    logic [CW-1:0]     ch_ptr;
    logic              mode_r;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_cnt;
    logic [DATA_W-1:0] fifo_dat;
    logic [31:0]       prime_need;
    logic              prime_ok;
    logic              tick;
    logic              pop;
    logic              ur_set;
    logic              ov_set;

    dac_stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat (in_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign in_ready = !fifo_full;

    // Mode is taken live while priming; RUN uses the value latched at entry.
    assign prime_need = (mode == MODE_ILV) ? 32'(CHANNELS) : 32'd1;
    assign prime_ok   = (32'(fifo_cnt) >= prime_need);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   state_nxt = prime_ok ? RUN : PRIME;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        tick   = (state == RUN) && enable && (cnt >= div);
        pop    = tick && !fifo_empty;
        ur_set = tick && fifo_empty;
        ov_set = in_valid && !in_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            ch_ptr <= '0;
            mode_r <= MODE_BCAST;
        end else begin
            if (state != RUN || !enable || tick) cnt <= '0;
            else                                 cnt <= cnt + DIV_W'(1);

            if (state != RUN) mode_r <= mode;

            if (state_nxt == IDLE) begin
                ch_ptr <= '0;
            end else if (pop && mode_r == MODE_ILV) begin
                ch_ptr <= (32'(ch_ptr) == CHANNELS - 1) ? '0 : ch_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dac_out       <= '0;
            dac_en        <= '0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            sample_strobe <= pop;
            if (!enable) begin
                dac_en <= '0;
            end else if (pop) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (mode_r == MODE_BCAST || CW'(c) == ch_ptr) begin
                        dac_out[c*DATA_W +: DATA_W] <= fifo_dat;
                        dac_en[c]                   <= 1'b1;
                    end
                end
            end
            underrun <= ur_set | (underrun & ~clr_flags);
            overflow <= ov_set | (overflow & ~clr_flags);
        end
    end

endmodule
